// File: rtl/uart_pkg.sv
// Shared constants and elaboration-time helpers for the UART baud tick generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Smallest usable integer divisor; a programmed value below this is raised
    // to it so the counter always spends at least one cycle away from zero and
    // the tick strobes can never sit high continuously.
    localparam int MIN_DIV = 2;

    // Width of an oversample phase index.
    function automatic int phase_width(input int oversample);
        return (oversample > 1) ? $clog2(oversample) : 1;
    endfunction

    // Reset divisor in fixed point (integer part above frac_bits, fraction
    // below), rounded to nearest: (clock_rate << frac_bits) / (baud * oversample).
    function automatic longint default_div(input longint clock_rate,
                                           input longint baud_rate,
                                           input longint oversample,
                                           input int     frac_bits);
        longint num;
        longint den;
        num = clock_rate << frac_bits;
        den = baud_rate * oversample;
        return (num + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/strobe bundle between the register block, the baud generator and the TX/RX engines.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are single-cycle enables with no handshake.
//
// master: register side / engines (drives enable, cfg_*, rx_resync; consumes strobes)
// slave : uart_baud_gen (consumes configuration; drives tx_tick, rx_tick, rx_sample, rx_phase)
interface uart_baud_gen_if
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int FRAC_BITS = 4,
    parameter int PHASE_W   = phase_width(16)
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] cfg_div_int;
    logic [FRAC_BITS-1:0] cfg_div_frac;
    logic                 cfg_load;
    logic                 rx_resync;
    logic                 tx_tick;
    logic                 rx_tick;
    logic                 rx_sample;
    logic [PHASE_W-1:0]   rx_phase;

    modport master (
        output enable, cfg_div_int, cfg_div_frac, cfg_load, rx_resync,
        input  tx_tick, rx_tick, rx_sample, rx_phase
    );

    modport slave (
        input  enable, cfg_div_int, cfg_div_frac, cfg_load, rx_resync,
        output tx_tick, rx_tick, rx_sample, rx_phase
    );

endinterface

// File: rtl/uart_frac_div.sv
// Fractional clock-enable divider: one base_tick every div_int + div_frac/2^FRAC_BITS cycles on average.
// Latency: base_tick is combinational from the counter; first tick div_int-1 cycles after restart ends.
// Backpressure: none; run low or restart high holds/reloads the divider and suppresses the tick.
//
// Ports: clk, resetn (async, active low); run, restart (control);
//        div_int, div_frac (shadow divisor); base_tick (strobe out).
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int                   DIV_WIDTH = 16,
    parameter int                   FRAC_BITS = 4,
    parameter logic [DIV_WIDTH-1:0] RST_CNT   = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 run,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    output logic                 base_tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic [FRAC_BITS:0]   sum;
    logic [DIV_WIDTH-1:0] reload_base;

    // The divisor is read straight from the shadow register only when the
    // counter is (re)loaded, so a new value takes effect on a whole-period
    // boundary: the period in progress always completes at its old length.
    // While idle the counter reloads every cycle, which makes a new value
    // visible immediately.
    always_comb begin
        reload_base = (div_int < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV - 1)
                                                      : div_int - 1'b1;
        sum         = {1'b0, acc_q} + {1'b0, div_frac};
        base_tick   = 1'b0;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        if (!run || restart) begin
            cnt_d = reload_base;
            acc_d = '0;
        end else if (cnt_q == '0) begin
            // Accumulator overflow stretches the next period by one cycle.
            base_tick = 1'b1;
            cnt_d     = reload_base + DIV_WIDTH'(sum[FRAC_BITS]);
            acc_d     = sum[FRAC_BITS-1:0];
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= RST_CNT;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud clock-enable generator: TX bit tick plus RX oversample tick, phase index and mid-bit sample strobe.
// Latency: strobes registered; first rx_tick div_int cycles after enable rises, first tx_tick after RX_OVERSAMPLE periods.
// Backpressure: none; enable low or rx_resync restarts the dividers, strobes are never held.
//
// Ports: clk, resetn (async, active low);
//        bus (slave): enable, cfg_div_int, cfg_div_frac, cfg_load, rx_resync in;
//                     tx_tick, rx_tick, rx_sample, rx_phase out.
// Optional build macro UART_BAUD_LEGACY_CLK_EN adds op_tx_clk / op_rx_clk,
// square waves toggling on each tx_tick / rx_tick for clocked legacy engines.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE    = 25000000,
    parameter int BAUD_RATE     = 115200,
    parameter int RX_OVERSAMPLE = 16,
    parameter int DIV_WIDTH     = 16,
    parameter int FRAC_BITS     = 4
) (
    input  logic clk,
    input  logic resetn,
`ifdef UART_BAUD_LEGACY_CLK_EN
    output logic op_tx_clk,
    output logic op_rx_clk,
`endif
    uart_baud_gen_if.slave bus
);

    localparam int     PHASE_W = phase_width(RX_OVERSAMPLE);
    localparam longint DEF_DIV = default_div(longint'(CLOCK_RATE), longint'(BAUD_RATE),
                                             longint'(RX_OVERSAMPLE), FRAC_BITS);
    localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(DEF_DIV >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_DIV);
    localparam logic [DIV_WIDTH-1:0] DEF_RELOAD =
        (DEF_INT < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV - 1) : DEF_INT - 1'b1;
    localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(RX_OVERSAMPLE - 1);
    localparam logic [PHASE_W-1:0] PH_SAMPLE = PHASE_W'(RX_OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0] shadow_int_q, shadow_int_d;
    logic [FRAC_BITS-1:0] shadow_frac_q, shadow_frac_d;
    logic                 rx_tick_q, rx_tick_d;
    logic                 rx_sample_q, rx_sample_d;
    logic [PHASE_W-1:0]   rx_phase_q, rx_phase_d;
    logic                 tx_tick_q, tx_tick_d;
    logic [PHASE_W-1:0]   tx_phase_q, tx_phase_d;
    logic                 rx_base, tx_base;

    uart_frac_div #(
        .DIV_WIDTH (DIV_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RST_CNT   (DEF_RELOAD)
    ) u_rx_div (
        .clk       (clk),
        .resetn    (resetn),
        .run       (bus.enable),
        .restart   (bus.rx_resync),
        .div_int   (shadow_int_q),
        .div_frac  (shadow_frac_q),
        .base_tick (rx_base)
    );

    uart_frac_div #(
        .DIV_WIDTH (DIV_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RST_CNT   (DEF_RELOAD)
    ) u_tx_div (
        .clk       (clk),
        .resetn    (resetn),
        .run       (bus.enable),
        .restart   (1'b0),
        .div_int   (shadow_int_q),
        .div_frac  (shadow_frac_q),
        .base_tick (tx_base)
    );

    always_comb begin
        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        rx_phase_d    = rx_phase_q;
        tx_phase_d    = tx_phase_q;
        // rx_base is already forced low by rx_resync inside the divider.
        rx_tick_d     = rx_base;
        // rx_phase_q already holds this tick's index: it advanced when the
        // previous rx_tick left the output register, at least a cycle ago.
        rx_sample_d   = rx_base && (rx_phase_q == PH_SAMPLE);
        tx_tick_d     = tx_base && (tx_phase_q == PH_LAST);

        if (bus.cfg_load) begin
            shadow_int_d  = bus.cfg_div_int;
            shadow_frac_d = bus.cfg_div_frac;
        end

        // The visible rx_phase names the tick currently on rx_tick, so it
        // advances as that tick leaves the register.
        if (!bus.enable || bus.rx_resync) begin
            rx_phase_d = '0;
        end else if (rx_tick_q) begin
            rx_phase_d = (rx_phase_q == PH_LAST) ? '0 : rx_phase_q + 1'b1;
        end

        if (!bus.enable) begin
            tx_phase_d = '0;
        end else if (tx_base) begin
            tx_phase_d = (tx_phase_q == PH_LAST) ? '0 : tx_phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_int_q  <= DEF_INT;
            shadow_frac_q <= DEF_FRAC;
            rx_tick_q     <= 1'b0;
            rx_sample_q   <= 1'b0;
            rx_phase_q    <= '0;
            tx_tick_q     <= 1'b0;
            tx_phase_q    <= '0;
        end else begin
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            rx_tick_q     <= rx_tick_d;
            rx_sample_q   <= rx_sample_d;
            rx_phase_q    <= rx_phase_d;
            tx_tick_q     <= tx_tick_d;
            tx_phase_q    <= tx_phase_d;
        end
    end

    assign bus.rx_tick   = rx_tick_q;
    assign bus.rx_sample = rx_sample_q;
    assign bus.rx_phase  = rx_phase_q;
    assign bus.tx_tick   = tx_tick_q;

`ifdef UART_BAUD_LEGACY_CLK_EN
    logic op_tx_clk_q, op_tx_clk_d;
    logic op_rx_clk_q, op_rx_clk_d;

    // Toggle once per tick: a 50% duty clock at half the tick rate, parked
    // low while the generator is idle.
    always_comb begin
        op_tx_clk_d = bus.enable ? (op_tx_clk_q ^ tx_tick_q) : 1'b0;
        op_rx_clk_d = bus.enable ? (op_rx_clk_q ^ rx_tick_q) : 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_tx_clk_q <= 1'b0;
            op_rx_clk_q <= 1'b0;
        end else begin
            op_tx_clk_q <= op_tx_clk_d;
            op_rx_clk_q <= op_rx_clk_d;
        end
    end

    assign op_tx_clk = op_tx_clk_q;
    assign op_rx_clk = op_rx_clk_q;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: expected tick times/phases are queued as each run starts, popped as strobes appear.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int OS = 16;
    localparam int FB = 4;

    typedef struct {
        int t;
        int ph;
        int smp;
    } ev_t;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_checks;
    int   n_pass;
    bit   mon_en;
    ev_t  rx_q[$];
    int   tx_q[$];

`ifdef UART_BAUD_LEGACY_CLK_EN
    logic op_tx_clk;
    logic op_rx_clk;
    bit   exp_op_tx;
    bit   exp_op_rx;
`endif

    uart_baud_gen_if #(.DIV_WIDTH(16), .FRAC_BITS(FB), .PHASE_W(4)) bus ();

    uart_baud_gen #(
        .CLOCK_RATE    (25000000),
        .BAUD_RATE     (115200),
        .RX_OVERSAMPLE (OS),
        .DIV_WIDTH     (16),
        .FRAC_BITS     (FB)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
`ifdef UART_BAUD_LEGACY_CLK_EN
        .op_tx_clk (op_tx_clk),
        .op_rx_clk (op_rx_clk),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Tick n after a restart whose first running cycle is t0.
    function automatic int tick_time(input int t0, input int d, input int f, input int n);
        return t0 + (n + 1) * d + ((n * f) >> FB);
    endfunction

    task automatic push_rx(input int t, input int ph);
        ev_t e;
        e.t   = t;
        e.ph  = ph;
        e.smp = (ph == OS / 2 - 1) ? 1 : 0;
        rx_q.push_back(e);
    endtask

    // Monitor: compare every strobe against the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (bus.rx_tick) begin
                if (rx_q.size() == 0) check("rx_unexpected", cyc, -1);
                else begin
                    e = rx_q.pop_front();
                    check("rx_time", cyc, e.t);
                    check("rx_phase", int'(bus.rx_phase), e.ph);
                    check("rx_sample", int'(bus.rx_sample), e.smp);
                end
            end else begin
                if (bus.rx_sample) check("rx_sample_alone", 1, 0);
                if (rx_q.size() != 0 && cyc > rx_q[0].t) begin
                    check("rx_missed", cyc, rx_q[0].t);
                    void'(rx_q.pop_front());
                end
            end
            if (bus.tx_tick) begin
                if (tx_q.size() == 0) check("tx_unexpected", cyc, -1);
                else check("tx_time", cyc, tx_q.pop_front());
            end else if (tx_q.size() != 0 && cyc > tx_q[0]) begin
                check("tx_missed", cyc, tx_q[0]);
                void'(tx_q.pop_front());
            end
        end
`ifdef UART_BAUD_LEGACY_CLK_EN
        if (bus.rx_tick) begin
            if (mon_en) check("op_rx_clk", int'(op_rx_clk), int'(exp_op_rx));
            exp_op_rx = !exp_op_rx;
        end
        if (bus.tx_tick) begin
            if (mon_en) check("op_tx_clk", int'(op_tx_clk), int'(exp_op_tx));
            exp_op_tx = !exp_op_tx;
        end
        if (!resetn || !bus.enable) begin
            exp_op_rx = 1'b0;
            exp_op_tx = 1'b0;
        end
`endif
    end

    task automatic load_cfg(input int di, input int df);
        @(posedge clk); #1;
        bus.cfg_div_int  = 16'(di);
        bus.cfg_div_frac = 4'(df);
        bus.cfg_load     = 1'b1;
        @(posedge clk); #1;
        bus.cfg_load     = 1'b0;
    endtask

    task automatic start_run(output int t0);
        @(posedge clk); #1;
        bus.enable = 1'b1;
        t0         = cyc;
        mon_en     = 1'b1;
    endtask

    // Run until the cycle after the last queued tick, pulsing resync/load on
    // the requested cycles, then stop and confirm nothing was left undelivered.
    task automatic run_window(input int last, input int rs_at, input int rs_phase,
                              input int ld_at, input int ld_int);
        while (cyc < last + 1) begin
            @(posedge clk); #1;
            bus.rx_resync = (cyc == rs_at);
            bus.cfg_load  = (cyc == ld_at);
            if (cyc == ld_at) bus.cfg_div_int = 16'(ld_int);
            if (cyc == rs_at) check("resync_phase", int'(bus.rx_phase), rs_phase);
        end
        mon_en        = 1'b0;
        bus.enable    = 1'b0;
        bus.rx_resync = 1'b0;
        bus.cfg_load  = 1'b0;
        check("rx_left", rx_q.size(), 0);
        check("tx_left", tx_q.size(), 0);
        rx_q.delete();
        tx_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frac(input int d, input int f, input int nticks);
        int t0;
        int last;
        start_run(t0);
        last = t0;
        for (int n = 0; n < nticks; n++) begin
            last = tick_time(t0, d, f, n);
            push_rx(last, n % OS);
            if (n % OS == OS - 1) tx_q.push_back(last);
        end
        run_window(last, -1, 0, -1, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int  t0;
        int  last;
        int  r;
        int  t;
        bit  found;

        n_checks         = 0;
        n_pass           = 0;
        mon_en           = 1'b0;
        resetn           = 1'b0;
        bus.enable       = 1'b0;
        bus.cfg_div_int  = '0;
        bus.cfg_div_frac = '0;
        bus.cfg_load     = 1'b0;
        bus.rx_resync    = 1'b0;
`ifdef UART_BAUD_LEGACY_CLK_EN
        exp_op_rx        = 1'b0;
        exp_op_tx        = 1'b0;
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_tick", int'(bus.rx_tick), 0);
        check("rst_tx_tick", int'(bus.tx_tick), 0);
        check("rst_rx_sample", int'(bus.rx_sample), 0);
        check("rst_rx_phase", int'(bus.rx_phase), 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_rx_tick", int'(bus.rx_tick), 0);

        // Reset default divisor 217/16 = 13 + 9/16; each tx bit 217 cycles.
        run_frac(13, 9, 320);

        // Integer divisor: rx every 4, tx every 64, sample at phase 7.
        load_cfg(4, 0);
        run_frac(4, 0, 48);

        // Half-cycle fraction: 4,4,5,4,5,... (72 cycles per 16 ticks).
        load_cfg(4, 8);
        run_frac(4, 8, 48);

        // Resync where tick 27 (phase 11) is due; TX keeps its schedule.
        load_cfg(5, 3);
        start_run(t0);
        r = tick_time(t0, 5, 3, 27) - 1;
        for (int n = 0; n < 27; n++) push_rx(tick_time(t0, 5, 3, n), n % OS);
        last = r;
        for (int m = 0; m < 31; m++) begin
            last = tick_time(r + 1, 5, 3, m);
            push_rx(last, m % OS);
        end
        for (int n = OS - 1; tick_time(t0, 5, 3, n) <= last; n += OS)
            tx_q.push_back(tick_time(t0, 5, 3, n));
        run_window(last, r, 11, -1, 0);

        // Divisor 1 clamps to 2; load of 6 coincides with a reload at tick 10,
        // so tick 11 still uses 2 and the new value starts after it.
        load_cfg(1, 0);
        start_run(t0);
        last = t0;
        for (int n = 0; n < 36; n++) begin
            t    = (n <= 11) ? t0 + 2 * n + 2 : t0 + 24 + 6 * (n - 11);
            last = t;
            push_rx(t, n % OS);
            if (n % OS == OS - 1) tx_q.push_back(t);
        end
        run_window(last, -1, 0, t0 + 21, 6);

        // Asynchronous reset in the middle of a tick cycle.
        load_cfg(4, 0);
        @(posedge clk); #1;
        bus.enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.rx_tick && bus.rx_phase == 4'd5) found = 1'b1;
        end
        check("rst_wait_tick", int'(found), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_rx_tick", int'(bus.rx_tick), 0);
        check("arst_tx_tick", int'(bus.tx_tick), 0);
        check("arst_rx_sample", int'(bus.rx_sample), 0);
        check("arst_rx_phase", int'(bus.rx_phase), 0);
`ifdef UART_BAUD_LEGACY_CLK_EN
        check("arst_op_rx_clk", int'(op_rx_clk), 0);
        check("arst_op_tx_clk", int'(op_tx_clk), 0);
`endif
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // cfg_div_int still shows 4 but was never loaded: defaults apply.
        run_frac(13, 9, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
